seq_magnitude_comparator: RTL and testbench

- Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands.
- Evaluates CHUNK bits per clock, MSB chunk first, and terminates early on the first differing chunk.
- Supports unsigned and two's-complement signed modes, with a start/busy/done handshake.
- Drop-in sequential successor to the small combinational comparators. Used where wide compares must not sit in a single-cycle timing path.

---
 rtl/seq_magnitude_comparator.sv | 131 +++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the latched operands CHUNK bits per clock,
// MSB chunk first, and stops on the first chunk that differs.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; results from the last compare are held
// COMPARE | examining chunk idx_q of the latched operands, one per edge
module seq_magnitude_comparator #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic                              signed_mode,
   input  logic [WIDTH-1:0]                  a,
   input  logic [WIDTH-1:0]                  b,
   output logic                              busy,
   output logic                              done,
   output logic                              equal,
   output logic                              greater,
   output logic                              lesser,
   output logic [$clog2(WIDTH/CHUNK+1)-1:0]  cycles
);

   localparam int NUM_CHUNKS = WIDTH / CHUNK;
   localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam int CNT_W      = $clog2(NUM_CHUNKS + 1);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_CHUNKS - 1);

   typedef enum logic {IDLE, COMPARE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic               sgn_q, sgn_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic               equal_q, equal_d, greater_q, greater_d, lesser_q, lesser_d;
   logic [CNT_W-1:0]   cycles_q, cycles_d;

   logic [CHUNK-1:0]   chunk_a, chunk_b;
   logic               sign_split;

   assign chunk_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
   assign chunk_b = b_q[int'(idx_q)*CHUNK +: CHUNK];
   // Only the top chunk can settle a signed compare by sign alone; below it the
   // bits are plain magnitude once the signs are known to match.
   assign sign_split = sgn_q && (idx_q == IDX_TOP) && (a_q[WIDTH-1] != b_q[WIDTH-1]);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      a_d       = a_q;
      b_d       = b_q;
      sgn_d     = sgn_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      equal_d   = equal_q;
      greater_d = greater_q;
      lesser_d  = lesser_q;
      cycles_d  = cycles_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = COMPARE;
               a_d     = a;
               b_d     = b;
               sgn_d   = signed_mode;
               idx_d   = IDX_TOP;
               busy_d  = 1'b1;
            end
         end
         COMPARE: begin
            if (sign_split || (chunk_a != chunk_b) || (idx_q == '0)) begin
               state_d  = IDLE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               cycles_d = CNT_W'(NUM_CHUNKS - int'(idx_q));
               if (sign_split) begin
                  equal_d   = 1'b0;
                  greater_d = b_q[WIDTH-1];
                  lesser_d  = a_q[WIDTH-1];
               end else begin
                  equal_d   = (chunk_a == chunk_b);
                  greater_d = (chunk_a > chunk_b);
                  lesser_d  = (chunk_a < chunk_b);
               end
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= IDX_TOP;
         a_q       <= '0;
         b_q       <= '0;
         sgn_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         equal_q   <= 1'b0;
         greater_q <= 1'b0;
         lesser_q  <= 1'b0;
         cycles_q  <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sgn_q     <= sgn_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         equal_q   <= equal_d;
         greater_q <= greater_d;
         lesser_q  <= lesser_d;
         cycles_q  <= cycles_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign equal   = equal_q;
   assign greater = greater_q;
   assign lesser  = lesser_q;
   assign cycles  = cycles_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: three parameter sets sharing one operand bus,
// checked against an arithmetic reference of the compare result and chunk count.
module tb_seq_magnitude_comparator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        sm = 1'b0;
   logic [31:0] a_bus = '0, b_bus = '0;
   int          sel = 0;

   logic busy16, done16, eq16, gt16, lt16;
   logic [2:0] cyc16;
   logic busy8, done8, eq8, gt8, lt8;
   logic [0:0] cyc8;
   logic busy32, done32, eq32, gt32, lt32;
   logic [4:0] cyc32;

   logic o_busy, o_done, o_eq, o_gt, o_lt;
   int   o_cyc;

   int n_checks = 0;
   int n_errors = 0;
   int prev_eq[3], prev_gt[3], prev_lt[3], prev_cyc[3];
   int width_of[3] = '{16, 8, 32};
   int chunk_of[3] = '{4, 8, 2};

   always #5 clk = ~clk;

   seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .signed_mode(sm),
      .a(a_bus[15:0]), .b(b_bus[15:0]), .busy(busy16), .done(done16),
      .equal(eq16), .greater(gt16), .lesser(lt16), .cycles(cyc16));

   seq_magnitude_comparator #(.WIDTH(8), .CHUNK(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .signed_mode(sm),
      .a(a_bus[7:0]), .b(b_bus[7:0]), .busy(busy8), .done(done8),
      .equal(eq8), .greater(gt8), .lesser(lt8), .cycles(cyc8));

   seq_magnitude_comparator #(.WIDTH(32), .CHUNK(2)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .start(start && sel == 2), .signed_mode(sm),
      .a(a_bus), .b(b_bus), .busy(busy32), .done(done32),
      .equal(eq32), .greater(gt32), .lesser(lt32), .cycles(cyc32));

   always_comb begin
      o_busy = busy16; o_done = done16; o_eq = eq16; o_gt = gt16; o_lt = lt16;
      o_cyc  = int'(cyc16);
      if (sel == 1) begin
         o_busy = busy8; o_done = done8; o_eq = eq8; o_gt = gt8; o_lt = lt8;
         o_cyc  = int'(cyc8);
      end else if (sel == 2) begin
         o_busy = busy32; o_done = done32; o_eq = eq32; o_gt = gt32; o_lt = lt32;
         o_cyc  = int'(cyc32);
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (sel=%0d a=%h b=%h sm=%0d)",
                  tag, got, exp, sel, a_bus, b_bus, sm);
      end
   endtask

   // res: 1 = a>b, -1 = a<b, 0 = equal; cyc = chunks the comparator must look at
   function automatic void ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                   input int w, input int ch, input bit s_mode,
                                   output int res, output int cyc);
      longint m  = (longint'(1) << w) - 1;
      longint va = longint'(a) & m;
      longint vb = longint'(b) & m;
      longint diff;
      int     p = 0;
      if (s_mode) begin
         if (va >= (longint'(1) << (w - 1))) va -= (longint'(1) << w);
         if (vb >= (longint'(1) << (w - 1))) vb -= (longint'(1) << w);
      end
      res = (va > vb) ? 1 : (va < vb) ? -1 : 0;
      diff = (longint'(a) ^ longint'(b)) & m;
      for (int i = 0; i < w; i++) if (diff[i]) p = i;
      if (res == 0)                          cyc = w / ch;
      else if (s_mode && ((va < 0) != (vb < 0))) cyc = 1;
      else                                   cyc = w / ch - p / ch;
   endfunction

   // Called on a negedge with the selected DUT idle (or in its done cycle).
   task automatic do_cmp(input int s, input logic [31:0] a, input logic [31:0] b, input bit s_mode);
      int res, cyc, k, lim;
      ref_cmp(a, b, width_of[s], chunk_of[s], s_mode, res, cyc);
      lim = width_of[s] / chunk_of[s] + 3;
      sel = s; a_bus = a; b_bus = b; sm = s_mode; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", int'(o_busy), 1);
      chk("done_is_pulse", int'(o_done), 0);
      chk("hold_equal", int'(o_eq), prev_eq[s]);
      chk("hold_greater", int'(o_gt), prev_gt[s]);
      chk("hold_lesser", int'(o_lt), prev_lt[s]);
      chk("hold_cycles", o_cyc, prev_cyc[s]);
      k = 0;
      while (!o_done && k < lim) begin
         @(negedge clk);
         k++;
      end
      if (!o_done) begin
         chk("done_timeout", 0, 1);
         return;
      end
      chk("latency", k, cyc);
      chk("equal", int'(o_eq), int'(res == 0));
      chk("greater", int'(o_gt), int'(res == 1));
      chk("lesser", int'(o_lt), int'(res == -1));
      chk("cycles", o_cyc, cyc);
      chk("busy_at_done", int'(o_busy), 0);
      prev_eq[s] = int'(res == 0); prev_gt[s] = int'(res == 1);
      prev_lt[s] = int'(res == -1); prev_cyc[s] = cyc;
   endtask

   task automatic clear_prev();
      for (int i = 0; i < 3; i++) begin
         prev_eq[i] = 0; prev_gt[i] = 0; prev_lt[i] = 0; prev_cyc[i] = 0;
      end
   endtask

   task automatic rand_pair(input int w, output logic [31:0] a, output logic [31:0] b);
      a = $urandom;
      case ($urandom_range(0, 3))
         0: b = $urandom;
         1: b = a;
         2: b = a ^ (32'd1 << $urandom_range(0, w - 1));
         default: b = a ^ ($urandom & ((32'd1 << $urandom_range(1, w - 1)) - 1));
      endcase
   endtask

   initial begin
      logic [31:0] ra, rb;
      int ndone, seen_lt, seen_cyc;
      clear_prev();
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         chk("rst_busy", int'(o_busy), 0);
         chk("rst_done", int'(o_done), 0);
         chk("rst_flags", int'({o_eq, o_gt, o_lt}), 0);
         chk("rst_cycles", o_cyc, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_cmp(0, 32'h1234, 32'h1234, 1'b0);
      do_cmp(0, 32'h8000, 32'h7FFF, 1'b0);
      do_cmp(0, 32'h8000, 32'h7FFF, 1'b1);
      do_cmp(0, 32'hFFFE, 32'hFFFF, 1'b1);
      do_cmp(0, 32'hFFFF, 32'hFFFE, 1'b1);
      do_cmp(0, 32'h12F0, 32'h1230, 1'b0);
      do_cmp(0, 32'h0001, 32'h0002, 1'b0);
      @(negedge clk);

      // operand churn and start pulses during a compare must not disturb it
      sel = 0; a_bus = 32'h1234; b_bus = 32'h1235; sm = 1'b0; start = 1'b1;
      ndone = 0; seen_lt = 0; seen_cyc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i < 3) begin
            a_bus = $urandom; b_bus = $urandom; start = (i != 1); sm = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (o_done) begin
            ndone++; seen_lt = int'(o_lt); seen_cyc = o_cyc;
         end
      end
      chk("busy_ignore_done_count", ndone, 1);
      chk("busy_ignore_lesser", seen_lt, 1);
      chk("busy_ignore_cycles", seen_cyc, 4);
      prev_eq[0] = 0; prev_gt[0] = 0; prev_lt[0] = 1; prev_cyc[0] = 4;

      // asynchronous reset in the middle of a compare
      a_bus = 32'h1234; b_bus = 32'h1234; sm = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", int'(o_busy), 0);
      chk("midrst_done", int'(o_done), 0);
      chk("midrst_flags", int'({o_eq, o_gt, o_lt}), 0);
      chk("midrst_cycles", o_cyc, 0);
      clear_prev();
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (6) begin
         @(negedge clk);
         if (o_done) ndone++;
      end
      chk("midrst_no_done", ndone, 0);

      do_cmp(1, 32'h80, 32'h7F, 1'b1);
      do_cmp(2, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
      do_cmp(2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1);

      for (int i = 0; i < 10000; i++) begin
         rand_pair(16, ra, rb);
         do_cmp(0, ra, rb, bit'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 1500; i++) begin
         rand_pair(8, ra, rb);
         do_cmp(1, ra, rb, bit'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 1500; i++) begin
         rand_pair(32, ra, rb);
         do_cmp(2, ra, rb, bit'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
